axo_prefetch_buffer: RTL and testbench

- Instruction prefetch queue between the RV32 core's fetch port (prog_re/prog_addr/prog_ready/prog_data) and a 32-bit word-aligned program memory bus.
- Fetches sequential aligned words ahead of the core and serves halfword-aligned instructions, including 32-bit instructions straddling two words (RVC-ready).
- Flushes and refetches when the core's prog_addr leaves the buffered window (branch taken, misprediction recovery).

---
 rtl/axo_prefetch_buffer_pkg.sv | 16 +
 rtl/axo_prefetch_fifo.sv | 71 +++++++
 rtl/axo_prefetch_buffer.sv | 111 +++++++++++
 tb/tb_axo_prefetch_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/axo_prefetch_buffer_pkg.sv
// Shared constants and helpers for the instruction prefetch buffer.
// Contents:
//   AXO_WORD_AW     - word address width of the program bus (30 bits, [31:2])
//   AXO_DATA_W      - program bus / instruction data width
//   axo_insn_length - 1 when the low halfword starts a 32-bit instruction
package axo_prefetch_buffer_pkg;

    localparam int unsigned AXO_WORD_AW = 30;
    localparam int unsigned AXO_DATA_W  = 32;

    // RISC-V length rule: quadrant bits 2'b11 mark a 32-bit encoding, all else is RVC.
    function automatic logic axo_insn_length(input logic [1:0] quadrant);
        return quadrant == 2'b11;
    endfunction

endpackage

// File: rtl/axo_prefetch_fifo.sv
// Circular word store for the prefetch buffer.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - empty the store (head kept, count cleared)
//   push, push_data     - append one word at the tail
//   pop_n               - number of words retired from the head this cycle
//   rd_ofs              - offset from head of read port 0; port 1 reads rd_ofs+1
//   count               - number of valid words
//   rd0_data, rd1_data  - storage read ports
module axo_prefetch_fifo
    import axo_prefetch_buffer_pkg::*;
#(
    parameter  int unsigned depth = 4,
    localparam int unsigned IW    = $clog2(depth),
    localparam int unsigned CW    = $clog2(depth + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [AXO_DATA_W-1:0] push_data,
    input  logic [CW-1:0]         pop_n,
    input  logic [IW-1:0]         rd_ofs,
    output logic [CW-1:0]         count,
    output logic [AXO_DATA_W-1:0] rd0_data,
    output logic [AXO_DATA_W-1:0] rd1_data
);

    logic [IW-1:0]         head_q, head_d;
    logic [CW-1:0]         count_q, count_d;
    logic [AXO_DATA_W-1:0] mem_q [depth];
    logic [AXO_DATA_W-1:0] mem_d [depth];
    logic [IW-1:0]         tail;
    logic [IW-1:0]         rd0_idx, rd1_idx;

    // Next-state: push at tail, pop from head; both may occur in one cycle.
    always_comb begin
        mem_d   = mem_q;
        tail    = head_q + IW'(count_q);
        head_d  = head_q + IW'(pop_n);
        count_d = count_q - pop_n + CW'(push);
        if (push) begin
            mem_d[tail] = push_data;
        end
        if (flush) begin
            head_d  = head_q;
            count_d = '0;
        end
        rd0_idx  = head_q + rd_ofs;
        rd1_idx  = head_q + rd_ofs + IW'(1);
        rd0_data = mem_q[rd0_idx];
        rd1_data = mem_q[rd1_idx];
        count    = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    // Data storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/axo_prefetch_buffer.sv
// Instruction prefetch queue between the core fetch port and a word-aligned
// program bus. Serves halfword-aligned instructions, including 32-bit
// instructions straddling two words, and refetches on leaving the window.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   prog_re, prog_addr[31:1]          - core fetch request (halfword address)
//   prog_ready, prog_data             - instruction valid / instruction bits
//   bus_re, bus_addr[31:2]            - memory read request, word address
//   bus_ready, bus_data               - read completion and data
// Build option: AXO_PREFETCH_BYPASS_EN forwards the completing bus word
// straight to prog_data when it is the last word the request is waiting on.
module axo_prefetch_buffer
    import axo_prefetch_buffer_pkg::*;
#(
    parameter int unsigned depth      = 4,
    parameter logic [31:0] entrypoint = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_re,
    input  logic [31:1] prog_addr,
    output logic        prog_ready,
    output logic [31:0] prog_data,
    output logic        bus_re,
    output logic [31:2] bus_addr,
    input  logic        bus_ready,
    input  logic [31:0] bus_data
);

    localparam int unsigned IW = $clog2(depth);
    localparam int unsigned CW = $clog2(depth + 1);
    localparam logic [AXO_WORD_AW-1:0] ENTRY_WORD = entrypoint[31:2];

    logic [AXO_WORD_AW-1:0] base_q, base_d;
    logic [AXO_WORD_AW-1:0] fetch_addr_q, fetch_addr_d;
    logic [AXO_WORD_AW-1:0] req_word, w, w1, count_w;
    logic [CW-1:0]          count, pop_n;
    logic [AXO_DATA_W-1:0]  rd0, rd1, word0, word1;
    logic                   fill, hit0, hit1, avail0, avail1;
    logic                   is32, straddle, miss, push;

    axo_prefetch_fifo #(.depth(depth)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (miss),
        .push      (push),
        .push_data (bus_data),
        .pop_n     (pop_n),
        .rd_ofs    (w[IW-1:0]),
        .count     (count),
        .rd0_data  (rd0),
        .rd1_data  (rd1)
    );

    // Lookup, bus control and window bookkeeping.
    always_comb begin
        req_word = prog_addr[31:2];
        w        = req_word - base_q;
        w1       = w + AXO_WORD_AW'(1);
        count_w  = AXO_WORD_AW'(count);
        bus_re   = !rst && (count < CW'(depth));
        fill     = bus_re && bus_ready;
        hit0     = w < count_w;
        hit1     = w1 < count_w;
`ifdef AXO_PREFETCH_BYPASS_EN
        // The word at base+count is exactly the one on the bus this cycle.
        word0  = (w == count_w) ? bus_data : rd0;
        word1  = (w1 == count_w) ? bus_data : rd1;
        avail0 = hit0 || (fill && (w == count_w));
        avail1 = hit1 || (fill && (w1 == count_w));
`else
        word0  = rd0;
        word1  = rd1;
        avail0 = hit0;
        avail1 = hit1;
`endif
        is32     = axo_insn_length(prog_addr[1] ? word0[17:16] : word0[1:0]);
        straddle = prog_addr[1] && is32;

        prog_ready = !rst && prog_re && avail0 && (!straddle || avail1);
        prog_data  = '0;
        if (!rst) begin
            prog_data = prog_addr[1] ? {word1[15:0], word0[31:16]} : word0;
        end

        // Waiting on the in-flight word is not a miss; a missing straddle
        // half implies word w is present, so it never reaches here either.
        miss  = prog_re && !hit0 && !((w == count_w) && bus_re);
        push  = fill && !miss;
        pop_n = (prog_re && hit0) ? CW'(w) : '0;

        base_d       = base_q + AXO_WORD_AW'(pop_n);
        fetch_addr_d = fetch_addr_q + AXO_WORD_AW'(push);
        if (miss) begin
            base_d       = req_word;
            fetch_addr_d = req_word;
        end
        bus_addr = fetch_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q       <= ENTRY_WORD;
            fetch_addr_q <= ENTRY_WORD;
        end else begin
            base_q       <= base_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

endmodule

// File: tb/tb_axo_prefetch_buffer.sv
// Self-checking bench for axo_prefetch_buffer: windowed reference model of
// the queue, a hashed program memory, directed latency cases and random traffic.
module tb_axo_prefetch_buffer;

    localparam int unsigned DEPTH   = 4;
    localparam logic [29:0] ENTRY_W = 30'h1000_0000;
    localparam logic [30:0] ENTRY_H = 31'h2000_0000;
`ifdef AXO_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_re;
    logic [31:1] prog_addr;
    logic        prog_ready;
    logic [31:0] prog_data;
    logic        bus_re;
    logic [31:2] bus_addr;
    logic        bus_ready;
    logic [31:0] bus_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference window: [m_base, m_base+m_count) buffered, m_fetch next read.
    logic [29:0] m_base, m_fetch;
    int          m_count;
    logic        obs_ready;
    logic        last_is32;

    always #5 clk = ~clk;

    axo_prefetch_buffer #(.depth(DEPTH), .entrypoint(32'h4000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_re    (prog_re),
        .prog_addr  (prog_addr),
        .prog_ready (prog_ready),
        .prog_data  (prog_data),
        .bus_re     (bus_re),
        .bus_addr   (bus_addr),
        .bus_ready  (bus_ready),
        .bus_data   (bus_data)
    );

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        logic [31:0] x;
        x = {a, 2'b00} ^ 32'h5bd1_e995;
        x = x * 32'h9e37_79b1;
        x = x ^ (x >> 15);
        x = x * 32'h85eb_ca6b;
        return x ^ (x >> 13);
    endfunction

    function automatic logic [15:0] half_at(input logic [30:0] h);
        logic [31:0] wd;
        wd = mem_word(h[30:1]);
        return h[0] ? wd[31:16] : wd[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check outputs, advance the model at posedge.
    task automatic step(input logic r, input logic re, input logic [30:0] pa, input logic br);
        logic [29:0] w, w1, cnt;
        logic [15:0] lo, hi;
        logic [31:0] mask;
        logic        e_bus_re, fill, is32, av0, av1, e_ready, miss;
        int          pop;
        rst       = r;
        prog_re   = re;
        prog_addr = pa;
        bus_ready = br;
        bus_data  = mem_word(bus_addr);
        #1;
        w        = pa[30:1] - m_base;
        w1       = w + 30'd1;
        cnt      = 30'(m_count);
        e_bus_re = !r && (m_count < int'(DEPTH));
        fill     = e_bus_re && br;
        lo       = half_at(pa);
        hi       = half_at(pa + 31'd1);
        is32     = (lo[1:0] == 2'b11);
        av0      = (w < cnt) || (BYP && fill && (w == cnt));
        av1      = (w1 < cnt) || (BYP && fill && (w1 == cnt));
        e_ready  = !r && re && av0 && (!(is32 && pa[0]) || av1);
        mask     = is32 ? 32'hffff_ffff : 32'h0000_ffff;

        check("bus_re", 32'(bus_re), 32'(e_bus_re));
        if (!r) check("bus_addr", 32'(bus_addr), 32'(m_fetch));
        check("prog_ready", 32'(prog_ready), 32'(e_ready));
        if (r) check("prog_data_rst", prog_data, 32'h0);
        else if (prog_ready && e_ready) check("prog_data", prog_data & mask, {hi, lo} & mask);
        obs_ready = prog_ready;
        last_is32 = is32;

        @(posedge clk);
        if (r) begin
            m_count = 0;
            m_base  = ENTRY_W;
            m_fetch = ENTRY_W;
        end else begin
            miss = re && !(w < cnt) && !((w == cnt) && e_bus_re);
            if (miss) begin
                m_count = 0;
                m_base  = pa[30:1];
                m_fetch = pa[30:1];
            end else begin
                pop     = (re && (w < cnt)) ? int'(w) : 0;
                m_base  = m_base + 30'(pop);
                m_count = m_count - pop + (fill ? 1 : 0);
                if (fill) m_fetch = m_fetch + 30'd1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [30:0] pa, tgt;
        logic        r, re, br, got, found;
        int          lat;
        rst = 1'b1; prog_re = 1'b0; prog_addr = '0; bus_ready = 1'b0; bus_data = '0;
        m_count = 0; m_base = ENTRY_W; m_fetch = ENTRY_W;
        obs_ready = 1'b0; last_is32 = 1'b0;
        @(negedge clk);

        // Reset: outputs forced low, even with a request and bus handshake present.
        step(1'b1, 1'b0, 31'd0, 1'b1);
        step(1'b1, 1'b1, ENTRY_H, 1'b1);

        // Fill from entrypoint with the core idle; bus_re drops once full.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, ENTRY_H, 1'b1);
        check("full_bus_re", 32'(bus_re), 32'd0);

        // Redirect out of the window: aligned target.
        lat = 0; got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b0, 1'b1, 31'h2000_0080, 1'b1);
            lat++;
            got = obs_ready;
        end
        check("miss_latency", 32'(lat), BYP ? 32'd2 : 32'd3);

        // Redirect to an unaligned 32-bit instruction straddling two words.
        found = 1'b0; tgt = 31'h2000_1001;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (half_at(tgt)[1:0] == 2'b11) found = 1'b1;
            else tgt = tgt + 31'd2;
        end
        check("straddle_found", 32'(found), 32'd1);
        lat = 0; got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b0, 1'b1, tgt, 1'b1);
            lat++;
            got = obs_ready;
        end
        check("straddle_latency", 32'(lat), BYP ? 32'd3 : 32'd4);

        // Stall on the in-flight word: no flush, address held, then resume.
        tgt = ENTRY_H + 31'h400;
        step(1'b0, 1'b1, tgt, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, tgt, 1'b0);
        check("stall_addr", 32'(bus_addr), 32'(tgt[30:1]));
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b0, 1'b1, tgt, 1'b1);
            got = obs_ready;
        end
        check("stall_resume", 32'(got), 32'd1);

        // Reset in the middle of an outstanding read.
        tgt = ENTRY_H + 31'h900;
        step(1'b0, 1'b1, tgt, 1'b0);
        step(1'b0, 1'b1, tgt, 1'b0);
        step(1'b1, 1'b1, tgt, 1'b0);
        step(1'b0, 1'b0, tgt, 1'b1);
        check("restart_addr", 32'(bus_addr), 32'h1000_0001);

        // Random traffic: sequential streams, idles, bus stalls, jumps, wrap.
        pa = ENTRY_H;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            re = ($urandom_range(0, 7) != 0);
            br = ($urandom_range(0, 3) != 0);
            step(r, re, pa, br);
            if (!r && re && obs_ready) pa = pa + 31'(last_is32 ? 2 : 1);
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 3))
                    0: pa = pa + 31'($urandom_range(0, 7));
                    1: pa = ENTRY_H + 31'($urandom_range(0, 255));
                    2: pa = 31'h7fff_fff0 + 31'($urandom_range(0, 15));
                    default: pa = pa - 31'($urandom_range(1, 6));
                endcase
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
